// File: rtl/conv_pool_if.sv
// Command, image-memory and result signals of the convolution/max-pool engine.
// Latency: none, wiring only.
// Backpressure: out_valid/out_ready handshake on results; memory reads are never stalled.
interface conv_pool_if #(
  parameter int BITS   = 8,
  parameter int ADDR_W = 10,
  parameter int WA_W   = 4
);
  logic              start;
  logic              w_we;
  logic [WA_W-1:0]   w_addr;
  logic [BITS-1:0]   w_data;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [BITS-1:0]   mem_data;
  logic [BITS-1:0]   out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  // Engine side.
  modport slave (
    input  start, w_we, w_addr, w_data, mem_data, out_ready,
    output mem_rd, mem_addr, out_data, out_valid, busy, done
  );

  // Controller / memory / consumer side.
  modport master (
    output start, w_we, w_addr, w_data, mem_data, out_ready,
    input  mem_rd, mem_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/conv_pool_engine.sv
// Single-image KxK convolution + ReLU/shift/saturate + PxP max-pool, one MAC per cycle.
// Latency: first result P*P*(K*K+2) edges after start; K*K+2 cycles per conv point.
// Backpressure: result held in OUT until out_ready; no memory reads while stalled.
module conv_pool_engine #(
  parameter int BITS        = 8,
  parameter int IMG_COLS    = 32,
  parameter int IMG_ROWS    = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int POOL_SIZE   = 2,
  parameter int ACC_W       = 20,
  parameter int SHIFT       = 0,
  parameter int ADDR_W      = 10
) (
  input logic         clk,
  input logic         reset,
  conv_pool_if.slave  bus
);

  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CONV_R = (IMG_ROWS - KERNEL_SIZE) / STRIDE + 1;
  localparam int CONV_C = (IMG_COLS - KERNEL_SIZE) / STRIDE + 1;
  localparam int POOL_R = CONV_R / POOL_SIZE;
  localparam int POOL_C = CONV_C / POOL_SIZE;
  localparam int TW     = $clog2(KK + 1);
  localparam int PW     = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int RW     = (POOL_R > 1) ? $clog2(POOL_R) : 1;
  localparam int CW     = (POOL_C > 1) ? $clog2(POOL_C) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CONV = 3'd1;
  localparam logic [2:0] S_POOL = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]              state_q, state_n;
  logic [TW-1:0]           tap_q, tap_n;
  logic [PW-1:0]           px_q, px_n, py_q, py_n;
  logic [CW-1:0]           pcol_q, pcol_n;
  logic [RW-1:0]           prow_q, prow_n;
  logic signed [ACC_W-1:0] acc_q, acc_n;
  logic [BITS-1:0]         max_q, max_n;
  logic                    mem_rd_q, mem_rd_n;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_n;
  logic signed [BITS-1:0]  weight_q [KK];

  logic [TW-1:0]           wsel;
  logic signed [ACC_W-1:0] pix_ext, w_ext, prod, shifted;
  logic [BITS-1:0]         relu_v;

  // Address of kernel tap t for conv point at pooled (prow,pcol), sub-position (py,px).
  function automatic logic [ADDR_W-1:0] tap_addr(input int prow, input int pcol,
                                                 input int py, input int px, input int t);
    int r0, c0;
    r0 = (prow * POOL_SIZE + py) * STRIDE;
    c0 = (pcol * POOL_SIZE + px) * STRIDE;
    return ADDR_W'((r0 + t / KERNEL_SIZE) * IMG_COLS + c0 + t % KERNEL_SIZE);
  endfunction

  // MAC operand: the pixel returned this cycle belongs to the tap issued last cycle.
  always_comb begin
    wsel    = (tap_q == '0) ? '0 : tap_q - TW'(1);
    pix_ext = $signed({{(ACC_W-BITS){1'b0}}, bus.mem_data});
    w_ext   = {{(ACC_W-BITS){weight_q[wsel][BITS-1]}}, weight_q[wsel]};
    prod    = pix_ext * w_ext;
  end

  // ReLU, arithmetic shift, then clamp to the unsigned output range.
  always_comb begin
    shifted = acc_q >>> SHIFT;
    relu_v  = shifted[BITS-1:0];
    if (acc_q[ACC_W-1]) relu_v = '0;
    else if (|shifted[ACC_W-1:BITS]) relu_v = '1;
  end

  // Next-state: sequencing of taps, sub-positions and pooled positions.
  always_comb begin
    state_n = state_q;
    tap_n   = tap_q;
    px_n    = px_q;
    py_n    = py_q;
    pcol_n  = pcol_q;
    prow_n  = prow_q;
    acc_n   = acc_q;
    max_n   = max_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_CONV;
          tap_n   = '0;
          px_n    = '0;
          py_n    = '0;
          pcol_n  = '0;
          prow_n  = '0;
          acc_n   = '0;
          max_n   = '0;
        end
      end
      S_CONV: begin
        if (tap_q != '0) acc_n = acc_q + prod;
        if (tap_q == TW'(KK)) state_n = S_POOL;
        else tap_n = tap_q + TW'(1);
      end
      S_POOL: begin
        if (relu_v > max_q) max_n = relu_v;
        tap_n = '0;
        acc_n = '0;
        if (px_q == PW'(POOL_SIZE - 1)) begin
          px_n = '0;
          if (py_q == PW'(POOL_SIZE - 1)) begin
            py_n    = '0;
            state_n = S_OUT;
          end else begin
            py_n    = py_q + PW'(1);
            state_n = S_CONV;
          end
        end else begin
          px_n    = px_q + PW'(1);
          state_n = S_CONV;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          max_n = '0;
          tap_n = '0;
          acc_n = '0;
          if (pcol_q == CW'(POOL_C - 1)) begin
            pcol_n = '0;
            if (prow_q == RW'(POOL_R - 1)) begin
              prow_n  = '0;
              state_n = S_DONE;
            end else begin
              prow_n  = prow_q + RW'(1);
              state_n = S_CONV;
            end
          end else begin
            pcol_n  = pcol_q + CW'(1);
            state_n = S_CONV;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Read request and address are registered from the next-state values.
  always_comb begin
    mem_rd_n   = (state_n == S_CONV) && (tap_n < TW'(KK));
    mem_addr_n = mem_addr_q;
    if (mem_rd_n)
      mem_addr_n = tap_addr(int'(prow_n), int'(pcol_n), int'(py_n), int'(px_n), int'(tap_n));
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tap_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      pcol_q     <= '0;
      prow_q     <= '0;
      acc_q      <= '0;
      max_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_n;
      tap_q      <= tap_n;
      px_q       <= px_n;
      py_q       <= py_n;
      pcol_q     <= pcol_n;
      prow_q     <= prow_n;
      acc_q      <= acc_n;
      max_q      <= max_n;
      mem_rd_q   <= mem_rd_n;
      mem_addr_q <= mem_addr_n;
    end
  end

  // Weight store: writable only while idle so a running image sees fixed weights.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KK; i++) weight_q[i] <= '0;
    end else if (state_q == S_IDLE && bus.w_we && int'(bus.w_addr) < KK) begin
      weight_q[bus.w_addr] <= bus.w_data;
    end
  end

  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = max_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed bench for conv_pool_engine on a 6x6 image, SHIFT=0 and SHIFT=4 instances in lockstep.
// Latency: checks first result timing and result cadence against the pool/conv cycle counts.
// Backpressure: exercises a 10-cycle out_ready stall on the first result.
module tb_conv_pool_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic w_we = 1'b0;
  logic [3:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic out_ready = 1'b1;
  logic [7:0] md0, md1;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  logic [7:0] img [0:1023];
  int wv [9];
  int q0 [$];
  int q1 [$];

  always #5 clk = ~clk;

  conv_pool_if #(.BITS(8), .ADDR_W(10), .WA_W(4)) c0 ();
  conv_pool_if #(.BITS(8), .ADDR_W(10), .WA_W(4)) c1 ();

  conv_pool_engine #(.BITS(8), .IMG_COLS(6), .IMG_ROWS(6), .KERNEL_SIZE(3), .STRIDE(1),
                     .POOL_SIZE(2), .ACC_W(20), .SHIFT(0), .ADDR_W(10))
    dut0 (.clk(clk), .reset(reset), .bus(c0));
  conv_pool_engine #(.BITS(8), .IMG_COLS(6), .IMG_ROWS(6), .KERNEL_SIZE(3), .STRIDE(1),
                     .POOL_SIZE(2), .ACC_W(20), .SHIFT(4), .ADDR_W(10))
    dut1 (.clk(clk), .reset(reset), .bus(c1));

  assign c0.start = start;     assign c1.start = start;
  assign c0.w_we = w_we;       assign c1.w_we = w_we;
  assign c0.w_addr = w_addr;   assign c1.w_addr = w_addr;
  assign c0.w_data = w_data;   assign c1.w_data = w_data;
  assign c0.out_ready = out_ready;
  assign c1.out_ready = out_ready;
  assign c0.mem_data = md0;
  assign c1.mem_data = md1;

  // Image memory: data one cycle after the read request.
  always @(posedge clk) begin
    if (c0.mem_rd) md0 <= img[c0.mem_addr];
    if (c1.mem_rd) md1 <= img[c1.mem_addr];
  end

  // Activity counters for the instance without shift.
  always @(negedge clk) begin
    if (c0.mem_rd) rd_cnt++;
    if (c0.done) done_cnt++;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Every accepted result is compared with the model queue of its instance.
  always @(negedge clk) begin
    if (!reset && c0.out_valid && out_ready) begin
      if (q0.size() == 0) check("dut0_unexpected_output", int'(c0.out_data), -1);
      else check("dut0_out_data", int'(c0.out_data), q0.pop_front());
    end
    if (!reset && c1.out_valid && out_ready) begin
      if (q1.size() == 0) check("dut1_unexpected_output", int'(c1.out_data), -1);
      else check("dut1_out_data", int'(c1.out_data), q1.pop_front());
    end
  end

  // Reference: direct convolution, ReLU, shift, clamp and max over the pool window.
  function automatic int model(input int pr, input int pc, input int sh);
    int best, s, v, r0, cc;
    best = 0;
    for (int py = 0; py < 2; py++)
      for (int px = 0; px < 2; px++) begin
        r0 = pr * 2 + py;
        cc = pc * 2 + px;
        s = 0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            s += int'(img[(r0 + ky) * 6 + cc + kx]) * wv[ky * 3 + kx];
        v = (s < 0) ? 0 : (s >>> sh);
        if (v > 255) v = 255;
        if (v > best) best = v;
      end
    return best;
  endfunction

  task automatic build_expected();
    q0.delete();
    q1.delete();
    for (int pr = 0; pr < 2; pr++)
      for (int pc = 0; pc < 2; pc++) begin
        q0.push_back(model(pr, pc, 0));
        q1.push_back(model(pr, pc, 4));
      end
  endtask

  task automatic set_img(input int mode);
    for (int i = 0; i < 1024; i++) img[i] = 8'd0;
    for (int i = 0; i < 36; i++)
      case (mode)
        0:       img[i] = 8'd1;
        1:       img[i] = 8'(i);
        default: img[i] = 8'd255;
      endcase
  endtask

  task automatic set_w(input int all, input int center_only);
    for (int t = 0; t < 9; t++) wv[t] = center_only ? ((t == 4) ? 1 : 0) : all;
  endtask

  task automatic load_w();
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      w_we = 1'b1;
      w_addr = 4'(t);
      w_data = 8'(wv[t]);
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic run_image(input bit stall, input bit poke, input bit timing);
    int cyc, first;
    bit seen;
    logic [7:0] held;
    out_ready = stall ? 1'b0 : 1'b1;
    rd_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    first = 0;
    seen = 1'b0;
    while (cyc < 2000 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 5) begin
        start = 1'b1; w_we = 1'b1; w_addr = 4'd0; w_data = 8'h55;
      end else if (poke && cyc == 6) begin
        start = 1'b0; w_we = 1'b0;
      end
      if (first == 0 && c0.out_valid) begin
        first = cyc;
        if (stall) begin
          held = c0.out_data;
          for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid_held", int'(c0.out_valid), 1);
            check("stall_data_held", int'(c0.out_data), int'(held));
            check("stall_no_read", int'(c0.mem_rd), 0);
          end
          out_ready = 1'b1;
        end
      end
      if (c0.done) seen = 1'b1;
    end
    check("done_seen", int'(seen), 1);
    if (timing) check("first_valid_edges", first, 44);
    @(posedge clk);
    #1;
    check("busy_after_done", int'(c0.busy || c1.busy), 0);
    check("done_pulse_count", done_cnt, 1);
    check("outputs_remaining", q0.size() + q1.size(), 0);
    if (timing) check("mem_rd_cycles", rd_cnt, 144);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    set_img(0);
    set_w(1, 0);
    #3;
    check("reset_outputs_zero", int'({c0.out_valid, c0.out_data, c0.mem_rd, c0.mem_addr, c0.busy, c0.done}), 0);
    check("reset_busy_dut1", int'(c1.busy), 0);
    @(negedge clk);
    reset = 1'b0;

    // All-ones image and weights.
    load_w();
    build_expected();
    check("model_pin_ones", q0[0], 9);
    check("model_pin_ones_shift4", q1[0], 0);
    run_image(1'b0, 1'b0, 1'b1);

    // Pixel = address, centre tap only.
    set_img(1);
    set_w(0, 1);
    load_w();
    build_expected();
    check("model_pin_center0", q0[0], 14);
    check("model_pin_center1", q0[1], 16);
    check("model_pin_center2", q0[2], 26);
    check("model_pin_center3", q0[3], 28);
    check("model_pin_center_shift4", q1[1], 1);
    run_image(1'b0, 1'b0, 1'b1);

    // Negative weights clip to zero.
    set_img(0);
    set_w(-1, 0);
    load_w();
    build_expected();
    check("model_pin_relu", q0[0], 0);
    run_image(1'b0, 1'b0, 1'b0);

    // Saturation.
    set_img(2);
    set_w(127, 0);
    load_w();
    build_expected();
    check("model_pin_sat", q0[3], 255);
    run_image(1'b0, 1'b0, 1'b0);

    // Output stall on the first result.
    set_img(1);
    set_w(0, 1);
    load_w();
    build_expected();
    run_image(1'b1, 1'b0, 1'b0);

    // start / w_we while busy must be ignored.
    build_expected();
    run_image(1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of convolution.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", int'(c0.busy), 1);
    reset = 1'b1;
    #1;
    check("midreset_outputs_zero", int'({c0.out_valid, c0.out_data, c0.mem_rd, c0.mem_addr, c0.busy, c0.done}), 0);
    @(negedge clk);
    reset = 1'b0;
    load_w();
    build_expected();
    run_image(1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pool_engine.md
CONV_POOL_ENGINE -- requirements
Module: conv_pool_engine

Interface
REQ-001 Parameter BITS, 8: pixel, weight and output width.
REQ-002 Parameter IMG_COLS, 32: image width in pixels.
REQ-003 Parameter IMG_ROWS, 32: image height in pixels.
REQ-004 Parameter KERNEL_SIZE, 3: K, square kernel edge.
REQ-005 Parameter STRIDE, 1: convolution stride.
REQ-006 Parameter POOL_SIZE, 2: P, square max-pool window; pool stride = P.
REQ-007 Parameter ACC_W, 20: signed accumulator width.
REQ-008 Parameter SHIFT, 0: right-shift applied after ReLU.
REQ-009 Parameter ADDR_W, 10: image memory address width.
REQ-010 clk  in  1  sole clock, rising edge.
REQ-011 reset  in  1  asynchronous, active-high reset.
REQ-012 start  in  1  single-cycle request to process one image.
REQ-013 w_we, w_addr, w_data  in  1 / clog2(K*K) / BITS  weight write port, signed weights.
REQ-014 mem_rd, mem_addr  out  1 / ADDR_W  image read request and registered address.
REQ-015 mem_data  in  BITS  unsigned pixel, valid exactly one cycle after mem_rd.
REQ-016 out_data, out_valid  out  BITS / 1  pooled result, held until accepted.
REQ-017 out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-018 busy, done  out  1 / 1  processing flag; one-cycle completion pulse.

Function
REQ-019 CONV_R = (IMG_ROWS-K)/STRIDE+1 and CONV_C = (IMG_COLS-K)/STRIDE+1; POOL_R = CONV_R/P and POOL_C = CONV_C/P (floor; leftover conv rows/cols are never computed).
REQ-020 FSM states: IDLE, CONV, POOL_UPD, OUT, DONE.
REQ-021 IDLE: w_we writes weight[w_addr]; start moves to CONV, busy=1, pooled index (0,0), sub-position (0,0), running max=0.
REQ-022 CONV lasts K*K+1 cycles: cycles 0..K*K-1 issue tap t (ky-major, kx-minor) with mem_rd=1; cycles 1..K*K accumulate acc += mem_data (zero-extended) * weight[t-1] (signed); acc cleared on CONV entry.
REQ-023 Tap address = (r0+ky)*IMG_COLS + c0 + kx, with r0 = (prow*P+py)*STRIDE and c0 = (pcol*P+px)*STRIDE.
REQ-024 POOL_UPD, 1 cycle: v = acc<0 ? 0 : acc>>>SHIFT, saturated to 2^BITS-1; max = max(max, v); advance px then py; after the last of P*P sub-positions go to OUT, else CONV.
REQ-025 OUT: out_valid=1, out_data=max, both stable until handshake; on handshake clear max, advance pcol then prow, go CONV, or DONE after the last pooled output.
REQ-026 DONE: done=1 for exactly one cycle, busy=0 from the following cycle, return to IDLE.
REQ-027 Latency: out_valid rises P*P*(K*K+2) edges after start is sampled; with out_ready held high, one output every P*P*(K*K+2)+1 cycles.
REQ-028 Outputs are produced in raster order (prow-major).
REQ-029 start and w_we are ignored while busy=1.
REQ-030 mem_rd=0 in every state except CONV tap-issue cycles; no reads while stalled in OUT.
REQ-031 Accumulator shall not wrap for the default parameters (9*255*127 fits ACC_W=20).

Reset
REQ-032 reset asserted forces IDLE immediately, without a clock edge: out_valid, out_data, mem_rd, mem_addr, busy and done = 0; acc, max and indices = 0.
REQ-033 Weights reset to 0; reset mid-operation discards the partial image, and the next start restarts from pooled (0,0).

Verification (IMG 6x6, K=3, STRIDE=1, P=2, SHIFT=0 unless stated: 4 outputs)
REQ-034 Pixels all 1, weights all 1, out_ready=1 -> outputs 9,9,9,9; first out_valid 44 edges after start; done pulses once; 144 mem_rd cycles total.
REQ-035 Pixel = address, only weight[4]=1 -> outputs 14,16,26,28 in order.
REQ-036 Weights all -1, pixels all 1 -> outputs 0,0,0,0 (ReLU); pixels 255, weights 127 -> 255,255,255,255 (saturation); SHIFT=4 with all-1 data -> 0.
REQ-037 out_ready low for 10 cycles at the first output -> out_valid and out_data stay constant, mem_rd stays 0, and the sequence resumes unchanged after release.
REQ-038 Assert reset mid-CONV between edges -> all outputs 0 immediately; start again after release -> full correct 4-output sequence from (0,0) after reloading weights.
REQ-039 start and w_we pulsed while busy -> no restart, weights unchanged, outputs identical to REQ-035.
